// File: rtl/game2048_pkg.sv
// game2048_pkg: shared types and constants for the 2048 move/merge datapath.
//   TILE_W      tile width; cells hold literal values (0 = empty, 2, 4, ... 2048)
//   tile_t      one cell
//   line_t      four cells, element 0 is the end tiles slide toward
//   board_t     [row][col] board
//   dir_t       move direction as encoded on cmd_dir
//   WIN_TILE    largest tile; never merges further
//   mme_state_t move_merge_engine FSM states
package game2048_pkg;

   localparam int unsigned TILE_W = 12;

   typedef logic [TILE_W-1:0] tile_t;
   typedef tile_t [3:0]       line_t;
   typedef tile_t [3:0][3:0]  board_t;

   typedef enum logic [1:0] {
      DirLeft  = 2'd0,
      DirRight = 2'd1,
      DirUp    = 2'd2,
      DirDown  = 2'd3
   } dir_t;

   localparam tile_t WIN_TILE = 12'd2048;

   typedef enum logic [2:0] {
      StIdle,
      StLine,
      StPlace,
      StWait,
      StDone
   } mme_state_t;

endpackage

// File: rtl/move_merge_engine_if.sv
// move_merge_engine_if: command, placer handshake and result bundle of the move engine.
//   cmd_valid/cmd_dir/cmd_ready   move request from the input/command logic
//   board_in                      current game board, sampled on command acceptance
//   board_out                     working board register, also the placer's board input
//   place_start/place_done        handshake to the random-tile placer
//   place_board                   placer result board
//   done/moved/score_add/won/place_ok  move result, valid while done is high
// Modports: slave = the engine, master = command logic plus placer.
interface move_merge_engine_if;
   import game2048_pkg::*;

   logic        cmd_valid;
   dir_t        cmd_dir;
   logic        cmd_ready;
   board_t      board_in;
   board_t      board_out;
   logic        place_start;
   logic        place_done;
   board_t      place_board;
   logic        done;
   logic        moved;
   logic [15:0] score_add;
   logic        won;
   logic        place_ok;

   modport slave (
      input  cmd_valid, cmd_dir, board_in, place_done, place_board,
      output cmd_ready, board_out, place_start, done, moved, score_add, won, place_ok
   );

   modport master (
      output cmd_valid, cmd_dir, board_in, place_done, place_board,
      input  cmd_ready, board_out, place_start, done, moved, score_add, won, place_ok
   );

endinterface

// File: rtl/line_merge.sv
// line_merge: combinational slide-and-merge of one 4-tile line toward element 0.
//   i_line     input tiles, element 0 is the end tiles slide toward
//   o_line     compacted and merged tiles
//   o_changed  any output element differs from its input
//   o_score    sum of the merged tile values (at most two merges of 2048)
//   o_win      a merge produced a 2048 tile
module line_merge
   import game2048_pkg::*;
(
   input  line_t       i_line,
   output line_t       o_line,
   output logic        o_changed,
   output logic [12:0] o_score,
   output logic        o_win
);

   line_t       w_comp;
   logic [1:0]  w_ccnt;
   tile_t [4:0] w_ext;
   logic [1:0]  w_ocnt;
   logic        w_skip;
   tile_t       w_sum;

   // Compact non-zero tiles toward element 0.
   always_comb begin
      w_comp = '0;
      w_ccnt = '0;
      for (int k = 0; k < 4; k++) begin
         if (i_line[k] != '0) begin
            w_comp[w_ccnt] = i_line[k];
            w_ccnt         = w_ccnt + 2'd1;
         end
      end
   end

   // Zero sentinel above element 3 lets the pair scan look at j+1 unconditionally.
   assign w_ext = {tile_t'(0), w_comp};

   // Pairwise scan; w_skip consumes the partner so no tile merges twice.
   always_comb begin
      o_line  = '0;
      o_score = '0;
      o_win   = 1'b0;
      w_ocnt  = '0;
      w_skip  = 1'b0;
      w_sum   = '0;
      for (int j = 0; j < 4; j++) begin
         if (w_skip) begin
            w_skip = 1'b0;
         end else if (w_ext[j] != '0) begin
            if ((w_ext[j] == w_ext[j+1]) && (w_ext[j] != WIN_TILE)) begin
               w_sum          = w_ext[j] << 1;
               o_line[w_ocnt] = w_sum;
               o_score        = o_score + {1'b0, w_sum};
               o_win          = o_win | (w_sum == WIN_TILE);
               w_skip         = 1'b1;
            end else begin
               o_line[w_ocnt] = w_ext[j];
            end
            w_ocnt = w_ocnt + 2'd1;
         end
      end
      o_changed = (o_line != i_line);
   end

endmodule

// File: rtl/move_merge_engine.sv
// move_merge_engine: executes one 2048 move on the 4x4 board, one line per cycle, then
// hands a changed board to the random-tile placer and reports the result.
//   clk, rst   clock; asynchronous active-high reset
//   bus        move_merge_engine_if.slave: command, placer handshake, result outputs
// Parameters: TILE_W tile width, PLACE_TIMEOUT max cycles spent waiting for place_done.
module move_merge_engine
   import game2048_pkg::*;
#(
   parameter int unsigned TILE_W        = 12,
   parameter int unsigned PLACE_TIMEOUT = 32
) (
   input  logic                clk,
   input  logic                rst,
   move_merge_engine_if.slave  bus
);

   localparam int unsigned CntW = $clog2(PLACE_TIMEOUT + 1);

   mme_state_t                     r_state, w_state_nxt;
   dir_t                           r_dir, w_dir_nxt;
   logic [1:0]                     r_idx, w_idx_nxt;
   logic [CntW-1:0]                r_cnt, w_cnt_nxt;
   logic [3:0][3:0][TILE_W-1:0]    r_board, w_board_nxt, w_board_wb;
   logic                           r_moved, w_moved_nxt;
   logic [15:0]                    r_score, w_score_nxt;
   logic                           r_won, w_won_nxt;
   logic                           r_place_ok, w_place_ok_nxt;

   line_t       w_line_in;
   line_t       w_line_out;
   logic        w_line_changed;
   logic [12:0] w_line_score;
   logic        w_line_win;

   // Gather the current line so element 0 is the edge tiles slide toward.
   always_comb begin
      w_line_in = '0;
      for (int k = 0; k < 4; k++) begin
         case (r_dir)
            DirLeft:  w_line_in[k] = r_board[r_idx][k];
            DirRight: w_line_in[k] = r_board[r_idx][3-k];
            DirUp:    w_line_in[k] = r_board[k][r_idx];
            DirDown:  w_line_in[k] = r_board[3-k][r_idx];
            default:  w_line_in[k] = '0;
         endcase
      end
   end

   line_merge u_line_merge (
      .i_line    (w_line_in),
      .o_line    (w_line_out),
      .o_changed (w_line_changed),
      .o_score   (w_line_score),
      .o_win     (w_line_win)
   );

   // Scatter the merged line back into the same cells, same order.
   always_comb begin
      w_board_wb = r_board;
      for (int k = 0; k < 4; k++) begin
         case (r_dir)
            DirLeft:  w_board_wb[r_idx][k]   = w_line_out[k];
            DirRight: w_board_wb[r_idx][3-k] = w_line_out[k];
            DirUp:    w_board_wb[k][r_idx]   = w_line_out[k];
            DirDown:  w_board_wb[3-k][r_idx] = w_line_out[k];
            default:  w_board_wb[r_idx][k]   = w_line_out[k];
         endcase
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_dir_nxt      = r_dir;
      w_idx_nxt      = r_idx;
      w_cnt_nxt      = r_cnt;
      w_board_nxt    = r_board;
      w_moved_nxt    = r_moved;
      w_score_nxt    = r_score;
      w_won_nxt      = r_won;
      w_place_ok_nxt = r_place_ok;
      case (r_state)
         StIdle: begin
            if (bus.cmd_valid) begin
               w_board_nxt    = bus.board_in;
               w_dir_nxt      = bus.cmd_dir;
               w_moved_nxt    = 1'b0;
               w_score_nxt    = '0;
               w_won_nxt      = 1'b0;
               w_place_ok_nxt = 1'b0;
               w_idx_nxt      = '0;
               w_cnt_nxt      = '0;
               w_state_nxt    = StLine;
            end
         end
         StLine: begin
            w_board_nxt = w_board_wb;
            w_moved_nxt = r_moved | w_line_changed;
            w_score_nxt = r_score + {3'b000, w_line_score};
            w_won_nxt   = r_won | w_line_win;
            w_idx_nxt   = r_idx + 2'd1;
            if (r_idx == 2'd3) begin
               // Decide on the registered flag plus this last line's change.
               w_state_nxt = (r_moved | w_line_changed) ? StPlace : StDone;
            end
         end
         StPlace: begin
            w_cnt_nxt   = '0;
            w_state_nxt = StWait;
         end
         StWait: begin
            if (bus.place_done) begin
               w_board_nxt    = bus.place_board;
               w_place_ok_nxt = 1'b1;
               w_state_nxt    = StDone;
            end else if (r_cnt == CntW'(PLACE_TIMEOUT - 1)) begin
               w_state_nxt = StDone;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StDone: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_dir      <= DirLeft;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_board    <= '0;
         r_moved    <= 1'b0;
         r_score    <= '0;
         r_won      <= 1'b0;
         r_place_ok <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_dir      <= w_dir_nxt;
         r_idx      <= w_idx_nxt;
         r_cnt      <= w_cnt_nxt;
         r_board    <= w_board_nxt;
         r_moved    <= w_moved_nxt;
         r_score    <= w_score_nxt;
         r_won      <= w_won_nxt;
         r_place_ok <= w_place_ok_nxt;
      end
   end

   // Strobes decode directly from state so reset drops them immediately.
   assign bus.cmd_ready   = (r_state == StIdle);
   assign bus.place_start = (r_state == StPlace);
   assign bus.done        = (r_state == StDone);
   assign bus.board_out   = r_board;
   assign bus.moved       = r_moved;
   assign bus.score_add   = r_score;
   assign bus.won         = r_won;
   assign bus.place_ok    = r_place_ok;

endmodule

// File: tb/tb_move_merge_engine.sv
// tb_move_merge_engine: scoreboard bench for move_merge_engine. Each move pushes its
// expected result when the command is driven; the entry is popped and compared when done
// pulses. Also covers placer timeout, stray inputs during a move and mid-move reset.
module tb_move_merge_engine;
   import game2048_pkg::*;

   localparam int PLACE_TIMEOUT = 32;

   typedef struct {
      board_t      board;
      logic        moved;
      logic [15:0] score;
      logic        won;
      logic        place_ok;
      int          done_cyc;
      int          ps_cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   exp_t sb_q[$];

   board_t b1, m1, p1, b2, m2, p2, b3, b4, m4, b6, m6, p6, b7, m7;

   move_merge_engine_if mif ();

   move_merge_engine #(
      .TILE_W        (12),
      .PLACE_TIMEOUT (PLACE_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // delay < 0 means the placer never answers; stray injects a command and a placer
   // completion during LINE, both of which must be ignored.
   task automatic run_move(input string name, input board_t b, input dir_t d,
                           input board_t merged, input logic e_moved,
                           input logic [15:0] e_score, input logic e_won,
                           input int delay, input board_t pb, input logic stray);
      exp_t e;
      exp_t g;
      int   ps_cnt;
      int   ps_cyc;
      bit   got_done;
      e.moved    = e_moved;
      e.score    = e_score;
      e.won      = e_won;
      e.place_ok = e_moved && (delay >= 0);
      e.board    = e.place_ok ? pb : merged;
      e.ps_cnt   = e_moved ? 1 : 0;
      e.done_cyc = !e_moved ? 4 : ((delay >= 0) ? 6 + delay : 5 + PLACE_TIMEOUT);
      sb_q.push_back(e);

      @(negedge clk);
      check_eq({name, ":ready_idle"}, mif.cmd_ready, 1'b1);
      mif.cmd_valid = 1'b1;
      mif.cmd_dir   = d;
      mif.board_in  = b;
      ps_cnt   = 0;
      ps_cyc   = -1;
      got_done = 1'b0;
      for (int k = 0; k < 100 && !got_done; k++) begin
         @(negedge clk);
         mif.cmd_valid  = 1'b0;
         mif.place_done = 1'b0;
         if (k == 0) begin
            mif.board_in = ~b;
            check_eq({name, ":ready_busy"}, mif.cmd_ready, 1'b0);
         end
         if (stray && k == 1) begin
            mif.cmd_valid   = 1'b1;
            mif.cmd_dir     = dir_t'(d + 2'd1);
            mif.place_done  = 1'b1;
            mif.place_board = ~pb;
         end
         if (delay >= 0 && k == 5 + delay) begin
            mif.place_done  = 1'b1;
            mif.place_board = pb;
         end
         if (mif.place_start) begin
            ps_cnt++;
            ps_cyc = k;
         end
         if (mif.done) begin
            got_done = 1'b1;
            check_eq({name, ":done_cyc"}, k, e.done_cyc);
            if (sb_q.size() == 0) begin
               check_eq({name, ":sb_entry"}, 0, 1);
            end else begin
               g = sb_q.pop_front();
               check_eq({name, ":board"}, mif.board_out, g.board);
               check_eq({name, ":moved"}, mif.moved, g.moved);
               check_eq({name, ":score"}, mif.score_add, g.score);
               check_eq({name, ":won"}, mif.won, g.won);
               check_eq({name, ":place_ok"}, mif.place_ok, g.place_ok);
               check_eq({name, ":ps_cnt"}, ps_cnt, g.ps_cnt);
            end
         end
      end
      if (!got_done) check_eq({name, ":done_seen"}, 0, 1);
      if (e_moved) check_eq({name, ":ps_cyc"}, ps_cyc, 4);
   endtask

   initial begin
      int done_seen;
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      mif.cmd_valid   = 1'b0;
      mif.cmd_dir     = DirLeft;
      mif.board_in    = '0;
      mif.place_done  = 1'b0;
      mif.place_board = '0;

      // LEFT on row [2,2,2,2] -> [4,4,0,0]; placer answers in the first WAIT cycle.
      b1 = '0; b1[0][0] = 12'd2; b1[0][1] = 12'd2; b1[0][2] = 12'd2; b1[0][3] = 12'd2;
      m1 = '0; m1[0][0] = 12'd4; m1[0][1] = 12'd4;
      p1 = m1; p1[2][1] = 12'd2;
      // RIGHT on row [4,4,8,0] -> [0,0,8,8]; the new 8 does not chain with the old 8.
      b2 = '0; b2[1][0] = 12'd4; b2[1][1] = 12'd4; b2[1][2] = 12'd8;
      m2 = '0; m2[1][2] = 12'd8; m2[1][3] = 12'd8;
      p2 = m2; p2[0][0] = 12'd4;
      // UP on columns already packed upward with no equal vertical neighbours.
      b3 = '0; b3[0][0] = 12'd2; b3[1][0] = 12'd4; b3[2][0] = 12'd8;
      b3[0][1] = 12'd16; b3[0][2] = 12'd2; b3[1][2] = 12'd4; b3[0][3] = 12'd2;
      // DOWN on column 2 [1024,1024,2048,2048]: the 1024 pair merges, 2048s never do.
      b4 = '0; b4[0][2] = 12'd1024; b4[1][2] = 12'd1024;
      b4[2][2] = 12'd2048; b4[3][2] = 12'd2048;
      m4 = '0; m4[1][2] = 12'd2048; m4[2][2] = 12'd2048; m4[3][2] = 12'd2048;
      // LEFT on row 3 [0,2,0,2] -> [4,0,0,0].
      b6 = '0; b6[3][1] = 12'd2; b6[3][3] = 12'd2;
      m6 = '0; m6[3][0] = 12'd4;
      p6 = m6; p6[0][3] = 12'd2;
      // RIGHT with two rows merging: [2,2,4,4] -> [0,0,4,8], [8,0,0,8] -> [0,0,0,16].
      b7 = '0; b7[0][0] = 12'd2; b7[0][1] = 12'd2; b7[0][2] = 12'd4; b7[0][3] = 12'd4;
      b7[2][0] = 12'd8; b7[2][3] = 12'd8;
      m7 = '0; m7[0][2] = 12'd4; m7[0][3] = 12'd8; m7[2][3] = 12'd16;

      repeat (3) @(negedge clk);
      check_eq("rst:ready", mif.cmd_ready, 1'b1);
      check_eq("rst:board", mif.board_out, '0);
      check_eq("rst:strobes", {mif.place_start, mif.done}, 2'b00);
      check_eq("rst:results", {mif.moved, mif.score_add, mif.won, mif.place_ok}, '0);
      rst = 1'b0;

      run_move("left",  b1, DirLeft,  m1, 1'b1, 16'd8,    1'b0, 0,  p1, 1'b0);
      run_move("right", b2, DirRight, m2, 1'b1, 16'd8,    1'b0, 3,  p2, 1'b1);
      run_move("up",    b3, DirUp,    b3, 1'b0, 16'd0,    1'b0, -1, b3, 1'b0);
      run_move("down",  b4, DirDown,  m4, 1'b1, 16'd2048, 1'b1, -1, m4, 1'b0);

      // Reset in cycle 2 of LINE: immediate return to IDLE, no done ever follows.
      @(negedge clk);
      mif.cmd_valid = 1'b1;
      mif.cmd_dir   = DirLeft;
      mif.board_in  = b1;
      @(negedge clk);
      mif.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("midrst:ready", mif.cmd_ready, 1'b1);
      check_eq("midrst:board", mif.board_out, '0);
      check_eq("midrst:strobes", {mif.place_start, mif.done}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (mif.done || mif.place_start) done_seen++;
      end
      check_eq("midrst:no_done", done_seen, 0);
      check_eq("midrst:ready_after", mif.cmd_ready, 1'b1);

      run_move("left2",  b6, DirLeft,  m6, 1'b1, 16'd4,  1'b0, 1, p6, 1'b0);
      run_move("right2", b7, DirRight, m7, 1'b1, 16'd28, 1'b0, 0, m7, 1'b1);

      check_eq("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
